// File: rtl/datapath_op_sequencer_if.sv
// Operand/result bus between the op sequencer and the datapath host.
// The sequencer is the master; the host under test is the slave.
interface datapath_op_sequencer_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] a_out;
    logic [DATA_WIDTH-1:0] b_out;
    logic [1:0]            op_sel_out;
    logic [DATA_WIDTH-1:0] result_in;
    logic                  valid_in;

    modport master (
        output a_out,
        output b_out,
        output op_sel_out,
        input  result_in,
        input  valid_in
    );

    modport slave (
        input  a_out,
        input  b_out,
        input  op_sel_out,
        output result_in,
        output valid_in
    );
endinterface

// File: rtl/datapath_op_sequencer.sv
// LFSR-driven stimulus engine with a golden ALU that scores the
// host's one-cycle-late result stream.
module datapath_op_sequencer #(
    parameter int               DATA_WIDTH = 16,
    parameter logic [15:0]      SEED       = 16'hACE1,
    parameter int               NUM_OPS    = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    datapath_op_sequencer_if.master bus,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [7:0]              mismatch_cnt,
    output logic                    first_bad_vld,
    output logic [7:0]              first_bad_idx
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    localparam logic [7:0] LAST_IDX = 8'(NUM_OPS - 1);

    state_e                state_q;
    logic [DATA_WIDTH-1:0] lfsr_q;
    logic [DATA_WIDTH-1:0] lfsr_d;
    logic [7:0]            idx_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [DATA_WIDTH-1:0] exp_d;
    logic                  cmp_q;
    logic [7:0]            cmp_idx_q;
    logic [7:0]            cnt_q;
    logic                  fbv_q;
    logic [7:0]            fbi_q;

    logic [DATA_WIDTH-1:0] b_val;
    logic [1:0]            op_val;
    logic                  run;
    logic                  miss;

    assign run    = (state_q == RUN);
    assign b_val  = {lfsr_q[7:0], lfsr_q[15:8]} ^ 16'h5A5A;
    assign op_val = idx_q[1:0];
    assign lfsr_d = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_comb begin
        exp_d = '0;
        unique case (op_val)
            2'b00:   exp_d = lfsr_q + b_val;
            2'b01:   exp_d = lfsr_q & b_val;
            2'b10:   exp_d = lfsr_q ^ b_val;
            default: exp_d = lfsr_q;
        endcase
    end

    // A missing valid counts as a wrong result.
    assign miss = cmp_q &&
                  (!bus.valid_in || (bus.result_in != exp_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= SEED;
            idx_q     <= '0;
            exp_q     <= '0;
            cmp_q     <= 1'b0;
            cmp_idx_q <= '0;
            cnt_q     <= '0;
            fbv_q     <= 1'b0;
            fbi_q     <= '0;
        end else begin
            cmp_q <= 1'b0;
            if (miss) begin
                if (cnt_q != 8'hFF)
                    cnt_q <= cnt_q + 8'd1;
                if (!fbv_q) begin
                    fbv_q <= 1'b1;
                    fbi_q <= cmp_idx_q;
                end
            end
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        lfsr_q  <= SEED;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        fbv_q   <= 1'b0;
                        fbi_q   <= '0;
                    end
                end
                RUN: begin
                    exp_q     <= exp_d;
                    cmp_q     <= 1'b1;
                    cmp_idx_q <= idx_q;
                    lfsr_q    <= lfsr_d;
                    idx_q     <= idx_q + 8'd1;
                    if (idx_q == LAST_IDX)
                        state_q <= DRAIN;
                end
                DRAIN: state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.a_out      = run ? lfsr_q : '0;
    assign bus.b_out      = run ? b_val  : '0;
    assign bus.op_sel_out = run ? op_val : 2'b00;

    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign pass          = done && (cnt_q == 8'd0);
    assign mismatch_cnt  = cnt_q;
    assign first_bad_vld = fbv_q;
    assign first_bad_idx = fbi_q;

endmodule

// File: doc/datapath_op_sequencer.md
# datapath_op_sequencer

Stimulus-and-check engine for the other end of the datapath host's operand/result interface. It drives `a`, `b` and `op_sel` into the host from a deterministic 16-bit LFSR and keeps its own golden ALU model. It captures the host's registered `result`/`valid` stream one cycle later and counts mismatches. Any nonzero payload XORed into the host result shows up as a mismatch count and a first-failing index.

## Interface
Parameters:
- `DATA_WIDTH`, 16, operand/result width; fixed at 16, the LFSR taps assume it.
- `SEED`, 16'hACE1, operand LFSR reset/start value; must be nonzero.
- `NUM_OPS`, 64, operations per run; legal range 1..255.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled in IDLE or DONE only.
- `a_out`  out  16  operand A to host.
- `b_out`  out  16  operand B to host.
- `op_sel_out`  out  2  op select to host: 00 add, 01 and, 10 xor, 11 pass A.
- `result_in`  in  16  host registered result.
- `valid_in`  in  1  host result valid.
- `busy`  out  1  high in RUN and DRAIN.
- `done`  out  1  high in DONE; held until next accepted `start` or reset.
- `pass`  out  1  `done & (mismatch_cnt == 0)`.
- `mismatch_cnt`  out  8  mismatches this run; saturates at 255.
- `first_bad_vld`  out  1  at least one mismatch this run.
- `first_bad_idx`  out  8  index of first mismatching op.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Reset behaviour: state IDLE; all outputs 0; LFSR = `SEED`; issue index 0; expected register 0.
- IDLE/DONE with `start`=1:
  - Next state RUN.
  - LFSR loaded with `SEED`; index cleared.
  - `mismatch_cnt`, `first_bad_vld`, `first_bad_idx` and `done` cleared.
- RUN, one op per cycle for op index i:
  - `a_out` = LFSR.
  - `b_out` = {LFSR[7:0], LFSR[15:8]} ^ 16'h5A5A.
  - `op_sel_out` = i[1:0].
  - Expected result registered alongside: golden ALU, add is modulo 2^16 with carry dropped.
  - LFSR advances each issued op: Fibonacci, shift left, new LSB = L[15]^L[13]^L[12]^L[10].
  - After op NUM_OPS-1 is issued, go to DRAIN.
- Compare, every cycle following an issue:
  - Mismatch when `valid_in`=0 or `result_in` != expected.
  - On mismatch: increment `mismatch_cnt` (saturating at 255).
  - On the first mismatch of a run only: set `first_bad_vld`, load `first_bad_idx` with that op's index.
- DRAIN: last compare, then DONE.
- Operand outputs outside RUN: a_out, b_out and op_sel_out are driven 0.
- `start` while busy: ignored.
- `rst_n` low mid-run: immediate return to the reset values; no partial status retained.

## Timing
- `start` accepted at edge k:
  - `busy`=1 and op 0 on outputs during cycle k+1.
  - Op i on outputs during cycle k+1+i.
  - Op i compared against `result_in` during cycle k+2+i (host latency is exactly 1 cycle).
  - DRAIN is cycle k+1+NUM_OPS; `done` rises in cycle k+2+NUM_OPS.
- Compare and count: the comparison for op i updates the status registers at the edge ending its compare cycle. A mismatch on op NUM_OPS-1 is therefore visible when `done` is first high.
- NUM_OPS=1: one RUN cycle, then DRAIN, then DONE.
- `start` in DONE: same timing as from IDLE; `done` drops at that edge.

## Test plan
- Ideal host model (1-cycle registered ALU), SEED=ACE1, NUM_OPS=64:
  - op0 drives a=ACE1, b=BBF6, op=00; result 68D7 is compared the next cycle.
  - op1 drives a=59C3, b=9903, op=01; expected 1903.
  - `done` rises 66 cycles after `start`, `pass`=1, `mismatch_cnt`=0.
- Host XORs 16'h0001 into result for op 5 only -> `mismatch_cnt`=1, `first_bad_vld`=1, `first_bad_idx`=5, `pass`=0.
- Host XORs nonzero value on every result, NUM_OPS=255 -> `mismatch_cnt`=255 (saturated), `first_bad_idx`=0.
- `valid_in` held 0 during ops 10..12 -> `mismatch_cnt`=3, `first_bad_idx`=10.
- Reset and `start` handling:
  - `rst_n` pulsed low at op 20 -> all outputs 0, state IDLE.
  - Subsequent `start` reruns from a=ACE1 with clean counters.
  - `start` pulsed during RUN is ignored: run length unchanged, `done` asserts at the same cycle.
